// File: rtl/bram_arbiter_if.sv
// Two-requester BRAM sharing bus: requester side plus the shared BRAM port.
// The arbiter takes the slave view; the environment takes the master view.
interface bram_arbiter_if #(
  parameter int ADDRESS_BITWIDTH     = 16,
  parameter int DATA_BITWIDTH        = 32,
  parameter int DATA_COLUMN_BITWIDTH = 8
);
  localparam int COLUMNS = DATA_BITWIDTH / DATA_COLUMN_BITWIDTH;

  logic                        req0;
  logic                        req1;
  logic [ADDRESS_BITWIDTH-1:0] addr0;
  logic [ADDRESS_BITWIDTH-1:0] addr1;
  logic [COLUMNS-1:0]          we0;
  logic [COLUMNS-1:0]          we1;
  logic [DATA_BITWIDTH-1:0]    wdata0;
  logic [DATA_BITWIDTH-1:0]    wdata1;
  logic                        ack0;
  logic                        ack1;
  logic [DATA_BITWIDTH-1:0]    rdata0;
  logic [DATA_BITWIDTH-1:0]    rdata1;
  logic [ADDRESS_BITWIDTH-1:0] bram_address;
  logic [COLUMNS-1:0]          bram_write_enable;
  logic [DATA_BITWIDTH-1:0]    bram_data_in;
  logic [DATA_BITWIDTH-1:0]    bram_data_out;
  logic                        busy;

  modport slave (
    input  req0, req1, addr0, addr1,
    input  we0, we1, wdata0, wdata1,
    input  bram_data_out,
    output ack0, ack1, rdata0, rdata1,
    output bram_address, bram_write_enable,
    output bram_data_in, busy
  );

  modport master (
    output req0, req1, addr0, addr1,
    output we0, we1, wdata0, wdata1,
    output bram_data_out,
    input  ack0, ack1, rdata0, rdata1,
    input  bram_address, bram_write_enable,
    input  bram_data_in, busy
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters.
// Each transaction runs IDLE -> ACCESS -> WAIT -> RESP; all outputs registered.
module bram_arbiter #(
  parameter int ADDRESS_BITWIDTH     = 16,
  parameter int DATA_BITWIDTH        = 32,
  parameter int DATA_COLUMN_BITWIDTH = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  bram_arbiter_if.slave bus
);
  localparam int COLUMNS = DATA_BITWIDTH / DATA_COLUMN_BITWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t                      state_q;
  logic                        owner_q;
  logic                        last_q;
  logic                        busy_q;
  logic                        ack0_q;
  logic                        ack1_q;
  logic [ADDRESS_BITWIDTH-1:0] addr_q;
  logic [COLUMNS-1:0]          we_q;
  logic [DATA_BITWIDTH-1:0]    wdata_q;
  logic [DATA_BITWIDTH-1:0]    rdata0_q;
  logic [DATA_BITWIDTH-1:0]    rdata1_q;

  logic                        any_req;
  logic                        owner_d;

  // Port 1 wins when alone, or when both ask and port 0 was served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    owner_d = bus.req1 & (~bus.req0 | ~last_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= owner_d;
            addr_q  <= owner_d ? bus.addr1  : bus.addr0;
            we_q    <= owner_d ? bus.we1    : bus.we0;
            wdata_q <= owner_d ? bus.wdata1 : bus.wdata0;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end else begin
            we_q <= '0;
          end
        end
        ACCESS: begin
          we_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // BRAM read data is valid now, one cycle after ACCESS.
          if (owner_q) begin
            rdata1_q <= bus.bram_data_out;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= bus.bram_data_out;
            ack0_q   <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.rdata0            = rdata0_q;
  assign bus.rdata1            = rdata1_q;
  assign bus.bram_address      = addr_q;
  assign bus.bram_write_enable = we_q;
  assign bus.bram_data_in      = wdata_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, golden memory scoreboard and
// round-robin reference, with directed cases followed by random traffic.
module tb_bram_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int COLS = DW / CW;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  bram_arbiter_if #(
    .ADDRESS_BITWIDTH(AW),
    .DATA_BITWIDTH(DW),
    .DATA_COLUMN_BITWIDTH(CW)
  ) bus ();

  bram_arbiter #(
    .ADDRESS_BITWIDTH(AW),
    .DATA_BITWIDTH(DW),
    .DATA_COLUMN_BITWIDTH(CW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [AW-1:0]   a;
    logic [COLS-1:0] w;
    logic [DW-1:0]   d;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  bit [DW-1:0] mem  [0:65535];
  bit [DW-1:0] gold [0:65535];

  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;

  logic [DW-1:0] rd_exp0;
  logic [DW-1:0] rd_exp1;
  logic [1:0]    hist[$];
  logic          last_srv;

  int checks = 0;
  int errors = 0;

  // Synchronous read-before-write BRAM with byte enables.
  always @(posedge sys_clk) begin
    bus.bram_data_out <= mem[bus.bram_address];
    for (int c = 0; c < COLS; c++)
      if (bus.bram_write_enable[c])
        mem[bus.bram_address][c*CW +: CW] <= bus.bram_data_in[c*CW +: CW];
    if (pre_en)
      mem[pre_a] <= pre_d;
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input txn_t t);
    logic [DW-1:0] r;
    r = old;
    for (int c = 0; c < COLS; c++)
      if (t.w[c]) r[c*CW +: CW] = t.d[c*CW +: CW];
    return r;
  endfunction

  // Monitor: pops the scoreboard on each ack and applies the reference rules.
  initial begin
    logic [1:0] prev_ack;
    logic [1:0] ack;
    logic [1:0] r;
    logic       expw;
    txn_t       t;
    prev_ack = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        q0.delete();
        q1.delete();
        hist.delete();
        last_srv = 1'b1;
        rd_exp0  = '0;
        rd_exp1  = '0;
        prev_ack = '0;
      end else begin
        hist.push_back({bus.req1, bus.req0});
        ack = {bus.ack1, bus.ack0};
        if (ack == 2'b11) chk("one_ack", 32'(ack), 32'(2'b01));
        for (int p = 0; p < 2; p++) begin
          if (ack[p]) begin
            checks++;
            if ((p == 0 ? q0.size() : q1.size()) == 0) begin
              errors++;
              $display("FAIL ack_no_grant: got ack%0d expected none", p);
            end else begin
              t = (p == 0) ? q0.pop_front() : q1.pop_front();
              if (p == 0) rd_exp0 = gold[t.a];
              else        rd_exp1 = gold[t.a];
              gold[t.a] = merge(gold[t.a], t);
              chk("rdata0", bus.rdata0, rd_exp0);
              chk("rdata1", bus.rdata1, rd_exp1);
            end
            if (hist.size() >= 4) begin
              r = hist[hist.size()-4];
              expw = (r == 2'b11) ? ~last_srv : r[1];
              chk("rr_winner", 32'(p), 32'(expw));
            end
            last_srv = p[0];
            chk("ack_width", 32'(prev_ack[p]), 32'(0));
            chk("busy_resp", 32'(bus.busy), 32'(1));
          end
        end
        prev_ack = ack;
        if (hist.size() > 8) void'(hist.pop_front());
      end
    end
  end

  task automatic issue(input int p, input logic [AW-1:0] a,
                       input logic [COLS-1:0] w, input logic [DW-1:0] d,
                       output int lat);
    txn_t t;
    logic got;
    t.a = a;
    t.w = w;
    t.d = d;
    if (p == 0) begin
      q0.push_back(t);
      bus.addr0 = a; bus.we0 = w; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      q1.push_back(t);
      bus.addr1 = a; bus.we1 = w; bus.wdata1 = d; bus.req1 = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge sys_clk);
      #1;
      lat++;
      got = (p == 0) ? bus.ack0 : bus.ack1;
    end
    chk($sformatf("ack%0d_timeout", p), 32'(got), 32'(1));
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int lat;
    logic [COLS-1:0] w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge sys_clk);
        #1;
      end
      w = ($urandom_range(0, 1) == 0) ? '0 : COLS'($urandom_range(1, 15));
      issue(p, AW'($urandom_range(0, 15)), w, $urandom, lat);
    end
  endtask

  initial begin
    int l0;
    int l1;
    logic [DW-1:0] hold0;
    logic [DW-1:0] v9;
    int stuck;
    txn_t t;

    bus.req0 = 0; bus.addr0 = '0; bus.we0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.addr1 = '0; bus.we1 = '0; bus.wdata1 = '0;

    #2 sys_rst = 1'b1;
    #1;
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.bram_write_enable), 0);
    chk("rst_addr", 32'(bus.bram_address), 0);
    chk("rst_din", bus.bram_data_in, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);

    pre_a  = AW'(7);
    pre_d  = 32'h1234_5678;
    gold[7] = 32'h1234_5678;
    pre_en = 1'b1;
    @(posedge sys_clk);
    #1 pre_en = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // Simultaneous requests right after reset: port 0 first.
    fork
      issue(0, AW'(3), '0, '0, l0);
      issue(1, AW'(4), '0, '0, l1);
    join
    chk("lat_both_p0", 32'(l0), 32'(3));
    chk("lat_both_p1", 32'(l1), 32'(7));
    repeat (2) @(posedge sys_clk);
    #1;

    // Byte write then read-back on port 0.
    t.a = AW'(5); t.w = 4'b0001; t.d = 32'habcd_ef12;
    q0.push_back(t);
    bus.addr0 = t.a; bus.we0 = t.w; bus.wdata0 = t.d; bus.req0 = 1'b1;
    @(posedge sys_clk); #1;
    chk("wr_we_t1", 32'(bus.bram_write_enable), 32'(4'b0001));
    chk("wr_addr_t1", 32'(bus.bram_address), 32'(5));
    chk("wr_din_t1", bus.bram_data_in, 32'habcd_ef12);
    @(posedge sys_clk); #1;
    chk("wr_we_t2", 32'(bus.bram_write_enable), 0);
    chk("wr_addr_t2", 32'(bus.bram_address), 32'(5));
    @(posedge sys_clk); #1;
    chk("wr_ack_t3", 32'(bus.ack0), 32'(1));
    bus.req0 = 1'b0; bus.we0 = '0;
    @(posedge sys_clk); #1;
    issue(0, AW'(5), '0, '0, l0);
    chk("rd_byte0", 32'(bus.rdata0[7:0]), 32'h12);

    // Preloaded read on port 1 leaves port 0 data alone.
    hold0 = bus.rdata0;
    @(posedge sys_clk); #1;
    issue(1, AW'(7), '0, '0, l1);
    chk("rd7_rdata1", bus.rdata1, 32'h1234_5678);
    chk("rd7_rdata0", bus.rdata0, hold0);
    @(posedge sys_clk); #1;
    chk("ack1_width", 32'(bus.ack1), 0);

    // Both ports saturating: strict alternation every 4 cycles.
    fork
      for (int i = 0; i < 4; i++)
        issue(0, AW'($urandom_range(0, 15)), '0, '0, l0);
      for (int i = 0; i < 4; i++)
        issue(1, AW'($urandom_range(0, 15)), '0, '0, l1);
      begin : sat_watch
        int tms[$];
        int prt[$];
        for (int c = 0; c < 60 && tms.size() < 8; c++) begin
          @(negedge sys_clk);
          if (bus.ack0 | bus.ack1) begin
            tms.push_back(c);
            prt.push_back(int'(bus.ack1));
          end
        end
        chk("sat_count", 32'(tms.size()), 32'(8));
        for (int i = 1; i < tms.size(); i++) begin
          chk("sat_spacing", 32'(tms[i] - tms[i-1]), 32'(4));
          chk("sat_alt", 32'(prt[i]), 32'(prt[i-1] == 0));
        end
      end
    join

    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    repeat (3) @(posedge sys_clk);
    #1;

    // Reset during ACCESS of a port 0 write aborts it.
    v9 = mem[9];
    t.a = AW'(9); t.w = 4'b1111; t.d = ~v9;
    q0.push_back(t);
    bus.addr0 = t.a; bus.we0 = t.w; bus.wdata0 = t.d; bus.req0 = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort_access", 32'(bus.bram_write_enable), 32'(4'b1111));
    sys_rst = 1'b1;
    bus.req0 = 1'b0;
    #1;
    chk("abort_we", 32'(bus.bram_write_enable), 0);
    chk("abort_addr", 32'(bus.bram_address), 0);
    chk("abort_din", bus.bram_data_in, 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rdata0", bus.rdata0, 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    stuck = 0;
    repeat (8) begin
      @(posedge sys_clk); #1;
      if (bus.ack0 || bus.busy) stuck++;
    end
    chk("abort_no_ack", 32'(stuck), 0);
    chk("abort_mem9", mem[9], v9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
